// File: rtl/stopwatch_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_counter_if
//  Description : Control and display bundle of the stopwatch timekeeping core.
//                The master side issues tick/pause pulses and adjust levels;
//                the slave side returns the BCD digits, run flag and blink
//                requests.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_counter_if;
    // Control toward the core
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_p;
    logic       adj;
    logic       sel;

    // Status from the core
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       blink_min;
    logic       blink_sec;

    modport master (
        output tick_1hz, tick_2hz, pause_p, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  running, blink_min, blink_sec
    );

    modport slave (
        input  tick_1hz, tick_2hz, pause_p, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones,
        output running, blink_min, blink_sec
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_counter
//  Description : MM:SS stopwatch core. Four BCD digits advance on tick_1hz
//                while running, hold while paused, and are hand-set one field
//                at a time on tick_2hz in adjust mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
    parameter int MAX_MIN = 59
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    stopwatch_counter_if.slave bus
);

    // Minutes wrap point split into BCD digits
    localparam logic [3:0] c_MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] c_MAX_ONES = 4'(MAX_MIN % 10);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_running;
    logic [3:0] r_min_tens;
    logic [3:0] r_min_ones;
    logic [3:0] r_sec_tens;
    logic [3:0] r_sec_ones;

    logic       w_cnt_en;
    logic       w_adj_en;
    logic       w_sec_wrap;
    logic       w_min_at_max;
    logic       w_inc_sec;
    logic       w_inc_min;
    logic [3:0] w_sec_tens_nxt;
    logic [3:0] w_sec_ones_nxt;
    logic [3:0] w_min_tens_nxt;
    logic [3:0] w_min_ones_nxt;

    // Counting uses the state before any same-cycle pause toggle; adjust
    // mode masks tick_1hz entirely, so a coincident 1 Hz tick cannot
    // double-increment.
    assign w_cnt_en     = ~bus.adj & bus.tick_1hz & (r_state == ST_RUN);
    assign w_adj_en     =  bus.adj & bus.tick_2hz;

    assign w_sec_wrap   = (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);
    assign w_min_at_max = (r_min_tens == c_MAX_TENS) && (r_min_ones == c_MAX_ONES);

    // Seconds carry into minutes only in normal counting; adjusting
    // seconds wraps them on their own.
    assign w_inc_sec    = w_cnt_en | (w_adj_en & bus.sel);
    assign w_inc_min    = (w_cnt_en & w_sec_wrap) | (w_adj_en & ~bus.sel);

    // Next seconds value: per-digit BCD increment, 59 wraps to 00
    always_comb begin
        w_sec_tens_nxt = r_sec_tens;
        w_sec_ones_nxt = r_sec_ones;
        if (r_sec_ones >= 4'd9) begin
            w_sec_ones_nxt = 4'd0;
            // >= rather than == so an out-of-range digit falls back to 0
            if (r_sec_tens >= 4'd5) begin
                w_sec_tens_nxt = 4'd0;
            end else begin
                w_sec_tens_nxt = r_sec_tens + 4'd1;
            end
        end else begin
            w_sec_ones_nxt = r_sec_ones + 4'd1;
        end
    end

    // Next minutes value: per-digit BCD increment, MAX_MIN wraps to 00
    always_comb begin
        w_min_tens_nxt = r_min_tens;
        w_min_ones_nxt = r_min_ones;
        if (w_min_at_max) begin
            w_min_tens_nxt = 4'd0;
            w_min_ones_nxt = 4'd0;
        end else if (r_min_ones >= 4'd9) begin
            w_min_ones_nxt = 4'd0;
            if (r_min_tens >= 4'd9) begin
                w_min_tens_nxt = 4'd0;
            end else begin
                w_min_tens_nxt = r_min_tens + 4'd1;
            end
        end else begin
            w_min_ones_nxt = r_min_ones + 4'd1;
        end
    end

    // Run/pause state machine together with the digit registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_running  <= 1'b1;
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
        end else begin
            if (bus.pause_p) begin
                case (r_state)
                    ST_RUN: begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                    end
                    default: begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                endcase
            end
            if (w_inc_sec) begin
                r_sec_tens <= w_sec_tens_nxt;
                r_sec_ones <= w_sec_ones_nxt;
            end
            if (w_inc_min) begin
                r_min_tens <= w_min_tens_nxt;
                r_min_ones <= w_min_ones_nxt;
            end
        end
    end

    assign bus.min_tens  = r_min_tens;
    assign bus.min_ones  = r_min_ones;
    assign bus.sec_tens  = r_sec_tens;
    assign bus.sec_ones  = r_sec_ones;
    assign bus.running   = r_running;

    // Blink requests track the adjust controls with no register in between
    assign bus.blink_min = bus.adj & ~bus.sel;
    assign bus.blink_sec = bus.adj &  bus.sel;

endmodule
`default_nettype wire

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timekeeping core of the stopwatch: holds an MM:SS value as four BCD digits and advances, pauses, or manually adjusts it under control of single-cycle enable pulses. Sits directly upstream of the seven-segment display driver inside `top`, which consumes the four digits and the blink flags to produce `seg`/`an`. Tick pulses come from the clock-divider stage; `pause_p` comes from the button debouncer.

## Interface
- `MAX_MIN`, 59: highest minutes value; minutes wrap from `MAX_MIN` to 0. Legal range 1..99.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick_1hz`  in  1  one-cycle count-enable pulse, 1 Hz.
- `tick_2hz`  in  1  one-cycle adjust-enable pulse, 2 Hz.
- `pause_p`  in  1  one-cycle pulse; toggles run/paused.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  level; adjust field select: 0 = minutes, 1 = seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits, registered.
- `running`  out  1  1 when in RUN state, registered.
- `blink_min`, `blink_sec`  out  1 each  display blink requests.

## Operation
- State machine has two states, RUN and PAUSED. `pause_p`=1 toggles the state; this applies in both normal and adjust mode.
- Normal mode (`adj`=0), RUN state, `tick_1hz`=1:
  - Seconds increment.
  - `sec_ones` 9→0 carries into `sec_tens`; seconds 59→00 carries into minutes.
  - `min_ones` 9→0 carries into `min_tens`.
  - Minutes at `MAX_MIN` with a seconds carry wrap to 00, so the full value goes `MAX_MIN`:59 → 00:00.
- Normal mode, PAUSED state: the digits hold.
- Adjust mode (`adj`=1):
  - `tick_1hz` is ignored.
  - On `tick_2hz`, only the selected field increments by 1, whether in RUN or PAUSED.
  - Seconds wrap 59→00 with no carry into minutes. Minutes wrap `MAX_MIN`→00.
- Blink outputs are combinational: `blink_min` = `adj` & ~`sel`, `blink_sec` = `adj` & `sel`.
- Arithmetic stays per-digit BCD. Every ones digit is always 0..9, and `sec_tens` is always 0..5.
- Simultaneous events:
  - `pause_p` with an applicable tick in the same cycle: the increment uses the pre-toggle state. A tick in RUN counts even if that same cycle pauses; a tick in PAUSED is dropped even if that same cycle resumes.
  - `tick_1hz` with `tick_2hz` in adjust mode: only the adjust increment applies.
  - `adj` or `sel` changing in the same cycle as a tick: the values sampled on that edge decide.

## Timing
- Reset: when `rst_n`=0 at a rising edge, all four digits become 0, the state becomes RUN, and `running`=1, all visible after that edge.
- Reset overrides every other input in the same cycle, including mid-count and mid-adjust.
- Latency: a tick sampled at edge k shows its new digit value after edge k, i.e. one cycle. The same applies to `pause_p` and `running`.
- The block never generates ticks itself. Ticks longer than one cycle increment once per cycle they are high; upstream must guarantee single-cycle pulses.
- `blink_*` follow `adj`/`sel` with zero cycles of latency. The blink rate is applied downstream.

## Test plan
- Reset then 60 `tick_1hz` pulses in RUN → 01:00. Continue to 09:59, then one more pulse → 10:00.
- Preload to 59:59 via adjust mode, return to normal mode, one `tick_1hz` → 00:00, `running`=1.
- `pause_p` pulse, then 5 `tick_1hz` pulses → digits unchanged and `running`=0. A second `pause_p` then 3 pulses → +3 s.
- `adj`=1, `sel`=1, seconds at 58, 3 `tick_2hz` pulses → seconds 01, minutes unchanged, `blink_sec`=1, `blink_min`=0. Then `tick_1hz` pulses have no effect.
- Same-cycle `pause_p` and `tick_1hz` while in RUN at 00:07 → 00:08 and `running`=0 one cycle later.
- `rst_n`=0 for one cycle at 12:34 while in adjust mode with a tick asserted → 00:00, RUN, on the next edge.
